mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the Avalon-MM port of mem_if.
- Master 0 is the stimulus reader (STIM fetching test vectors); master 1 is the result writer (CHECK writeback).
- Round-robin grant with an optional per-master lock, so a multi-word record (e.g. result word plus meta word) lands contiguously.
- A lock-hold limit bounds starvation of the other master.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter_rr_pick2.sv | 18 +
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the two-master Avalon-MM arbiter in front of mem_if.
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 20;
    localparam int MEM_DATA_WIDTH = 16;
    localparam int MEM_BE_WIDTH   = MEM_DATA_WIDTH / 8;
    localparam int MEM_MAX_LOCK   = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    function automatic logic [1:0] grant_of(arb_state_e st);
        case (st)
            ARB_GNT0: return 2'b01;
            ARB_GNT1: return 2'b10;
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Avalon-MM port bundle plus a lock request; master drives the command side.
interface mem_arbiter_if
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int BE_WIDTH   = MEM_BE_WIDTH
);

    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  lock;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  waitrequest;

    modport master (
        output address, byteenable, read, write, writedata, lock,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, byteenable, read, write, writedata, lock,
        output readdata, waitrequest
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on contention the requester that was not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (&req) begin
            winner = ~last;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded per-master lock, muxing two Avalon-MM masters onto mem_if.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int MAX_LOCK   = MEM_MAX_LOCK
) (
    input  logic          clock,
    input  logic          reset_n,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s,
    output logic [1:0]    grant
);

    localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;

    logic [1:0] req;
    logic       pick_winner, pick_valid;
    logic       granted, gidx, req_g, req_o, lock_g, done;
    arb_state_e other_state;

    logic [ADDR_WIDTH-1:0] sel_address;
    logic [BE_WIDTH-1:0]   sel_byteenable;
    logic [DATA_WIDTH-1:0] sel_writedata;
    logic                  sel_read, sel_write, sel_lock;
    logic                  m0_wait, m1_wait;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    rr_pick2 u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        granted     = (state_q == ARB_GNT0) || (state_q == ARB_GNT1);
        gidx        = (state_q == ARB_GNT1);
        req_g       = req[gidx];
        req_o       = req[~gidx];
        lock_g      = gidx ? m1.lock : m0.lock;
        done        = granted && req_g && !s.waitrequest;
        other_state = gidx ? ARB_GNT0 : ARB_GNT1;
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d    = pick_winner ? ARB_GNT1 : ARB_GNT0;
                    lock_cnt_d = '0;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                if (done) begin
                    last_d = gidx;
                    if (lock_g && (lock_cnt_q < LOCK_LAST)) begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end else begin
                        lock_cnt_d = '0;
                        if (req_o) begin
                            state_d = other_state;
                        end else if (!req_g) begin
                            state_d = ARB_IDLE;
                        end
                    end
                end else if (!req_g) begin
                    // Locked grant with nothing pending: lock_cnt counts the other side's wait.
                    if (!lock_g) begin
                        state_d    = ARB_IDLE;
                        lock_cnt_d = '0;
                    end else if (req_o) begin
                        if (lock_cnt_q >= LOCK_LAST) begin
                            state_d    = other_state;
                            lock_cnt_d = '0;
                        end else begin
                            lock_cnt_d = lock_cnt_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Slave side is purely combinational from state so reset drops it immediately.
    always_comb begin
        sel_address    = '0;
        sel_byteenable = '0;
        sel_writedata  = '0;
        sel_read       = 1'b0;
        sel_write      = 1'b0;
        sel_lock       = 1'b0;
        m0_wait        = 1'b1;
        m1_wait        = 1'b1;
        case (state_q)
            ARB_GNT0: begin
                sel_address    = m0.address;
                sel_byteenable = m0.byteenable;
                sel_writedata  = m0.writedata;
                sel_read       = m0.read & ~m0.write;
                sel_write      = m0.write;
                sel_lock       = m0.lock;
                m0_wait        = s.waitrequest;
            end
            ARB_GNT1: begin
                sel_address    = m1.address;
                sel_byteenable = m1.byteenable;
                sel_writedata  = m1.writedata;
                sel_read       = m1.read & ~m1.write;
                sel_write      = m1.write;
                sel_lock       = m1.lock;
                m1_wait        = s.waitrequest;
            end
            default: ;
        endcase
    end

    assign s.address      = sel_address;
    assign s.byteenable   = sel_byteenable;
    assign s.writedata    = sel_writedata;
    assign s.read         = sel_read;
    assign s.write        = sel_write;
    assign s.lock         = sel_lock;
    assign m0.waitrequest = m0_wait;
    assign m1.waitrequest = m1_wait;
    assign m0.readdata    = s.readdata;
    assign m1.readdata    = s.readdata;
    assign grant          = grant_of(state_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table plus a transfer scoreboard for multi-cycle sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int ML = 4;
    localparam logic [AW-1:0] M0_ADDR  = 20'h00010;
    localparam logic [AW-1:0] M1_ADDR  = 20'h00100;
    localparam logic [DW-1:0] M1_WDATA = 16'h1234;
    localparam logic [DW-1:0] RDATA    = 16'hBEEF;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] grant;

    always #5 clock = ~clock;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) m0_bus ();
    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) m1_bus ();
    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) s_bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_LOCK(ML)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .grant   (grant)
    );

    typedef struct {
        logic          who;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xfer_t;

    typedef struct {
        bit       r0, w1, l1, sw;
        bit [1:0] gnt;
        bit       srd, swr, wq0, wq1, push;
    } vec_t;

    xfer_t exp_q[$];
    vec_t  vt[13];
    int    n_cmp = 0;
    int    n_fail = 0;
    logic  done_seen;
    logic  done_who;

    function automatic vec_t v(input bit r0, w1, l1, sw, input bit [1:0] gnt,
                               input bit srd, swr, wq0, wq1, push);
        vec_t r;
        r.r0 = r0; r.w1 = w1; r.l1 = l1; r.sw = sw; r.gnt = gnt;
        r.srd = srd; r.swr = swr; r.wq0 = wq0; r.wq1 = wq1; r.push = push;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic who, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        xfer_t e;
        e.who = who; e.wr = wr; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Observe one cycle at the falling edge; any completed transfer is checked against the scoreboard.
    task automatic sample();
        xfer_t e;
        @(negedge clock);
        done_seen = (s_bus.read | s_bus.write) & ~s_bus.waitrequest;
        done_who  = grant[1];
        if (done_seen) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: transfer at addr 0x%0h with nothing expected", s_bus.address);
            end else begin
                e = exp_q.pop_front();
                check("sb_grant", grant, e.who ? 2'b10 : 2'b01);
                check("sb_is_write", s_bus.write, e.wr);
                check("sb_address", s_bus.address, e.addr);
                if (e.wr) check("sb_wdata", s_bus.writedata, e.data);
                else      check("sb_rdata", e.who ? m1_bus.readdata : m0_bus.readdata, e.data);
            end
        end
    endtask

    task automatic to_drive();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n, input int budget, input bit drop, output int gap);
        int got;
        int last_c;
        got = 0;
        last_c = 0;
        gap = -1;
        for (int c = 0; c < budget && got < n; c++) begin
            sample();
            if (done_seen) begin
                if (got > 0) gap = c - last_c;
                last_c = c;
                got++;
            end
            to_drive();
            if (drop && done_seen) begin
                if (done_who) begin m1_bus.write = 1'b0; m1_bus.read = 1'b0; end
                else          begin m0_bus.write = 1'b0; m0_bus.read = 1'b0; end
            end
        end
        if (got < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_timeout: got %0d transfers, expected %0d", got, n);
        end
    endtask

    task automatic idle_out();
        m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.lock = 1'b0;
        m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.lock = 1'b0;
        sample(); to_drive();
        sample(); to_drive();
    endtask

    initial begin
        int gap;
        m0_bus.address = M0_ADDR; m0_bus.byteenable = 2'b11; m0_bus.writedata = '0;
        m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.lock = 1'b0;
        m1_bus.address = M1_ADDR; m1_bus.byteenable = 2'b11; m1_bus.writedata = M1_WDATA;
        m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.lock = 1'b0;
        s_bus.readdata = RDATA; s_bus.waitrequest = 1'b0;

        //           r0 w1 l1 sw  gnt    srd swr wq0 wq1 push
        vt[0]  = v(L, L, L, L, 2'b00, L, L, H, H, L);
        vt[1]  = v(H, H, L, L, 2'b00, L, L, H, H, L);
        vt[2]  = v(H, H, L, L, 2'b01, H, L, L, H, H);
        vt[3]  = v(L, H, L, L, 2'b10, L, H, H, L, H);
        vt[4]  = v(L, L, L, L, 2'b10, L, L, H, L, L);
        vt[5]  = v(H, H, L, L, 2'b00, L, L, H, H, L);
        vt[6]  = v(H, H, L, H, 2'b01, H, L, H, H, L);
        vt[7]  = v(H, H, L, L, 2'b01, H, L, L, H, H);
        vt[8]  = v(H, H, H, L, 2'b10, L, H, H, L, H);
        vt[9]  = v(H, H, L, L, 2'b10, L, H, H, L, H);
        vt[10] = v(H, L, L, L, 2'b01, H, L, L, H, H);
        vt[11] = v(L, L, L, L, 2'b01, L, L, L, H, L);
        vt[12] = v(L, L, L, L, 2'b00, L, L, H, H, L);

        #12;
        check("rst_grant", grant, 2'b00);
        check("rst_s_read", s_bus.read, 1'b0);
        check("rst_s_write", s_bus.write, 1'b0);
        check("rst_m0_wait", m0_bus.waitrequest, 1'b1);
        check("rst_m1_wait", m1_bus.waitrequest, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        to_drive();

        for (int i = 0; i < 13; i++) begin
            m0_bus.read = vt[i].r0;
            m1_bus.write = vt[i].w1;
            m1_bus.lock = vt[i].l1;
            s_bus.waitrequest = vt[i].sw;
            if (vt[i].push) begin
                if (vt[i].gnt == 2'b10) push(1'b1, vt[i].swr, M1_ADDR, vt[i].swr ? M1_WDATA : RDATA);
                else                    push(1'b0, vt[i].swr, M0_ADDR, RDATA);
            end
            sample();
            check($sformatf("tbl%0d_grant", i), grant, vt[i].gnt);
            check($sformatf("tbl%0d_s_read", i), s_bus.read, vt[i].srd);
            check($sformatf("tbl%0d_s_write", i), s_bus.write, vt[i].swr);
            check($sformatf("tbl%0d_m0_wait", i), m0_bus.waitrequest, vt[i].wq0);
            check($sformatf("tbl%0d_m1_wait", i), m1_bus.waitrequest, vt[i].wq1);
            to_drive();
        end

        // Fresh reset, then ten contention rounds: m0 first each time, m1 right behind.
        reset_n = 1'b0;
        to_drive();
        reset_n = 1'b1;
        for (int r = 0; r < 10; r++) begin
            push(1'b0, 1'b0, M0_ADDR, RDATA);
            push(1'b1, 1'b1, M1_ADDR, M1_WDATA);
            m0_bus.read = 1'b1;
            m1_bus.write = 1'b1;
            run(2, 8, 1'b1, gap);
            check($sformatf("rr%0d_no_bubble", r), gap, 1);
            idle_out();
        end

        // Lock limit: m1 holds lock and keeps writing, m0 waits; m1 gets exactly ML transfers.
        m1_bus.write = 1'b1; m1_bus.lock = 1'b1;
        sample(); to_drive();
        m0_bus.read = 1'b1;
        for (int k = 0; k < ML; k++) push(1'b1, 1'b1, M1_ADDR, M1_WDATA);
        push(1'b0, 1'b0, M0_ADDR, RDATA);
        run(ML + 1, 20, 1'b0, gap);
        check("lim_m0_after_m1", gap, 1);
        idle_out();

        // Locked two-word record from m1 while m0 requests throughout.
        m1_bus.address = 20'h00100; m1_bus.writedata = 16'h1234; m1_bus.lock = 1'b1; m1_bus.write = 1'b1;
        m0_bus.read = 1'b1;
        push(1'b1, 1'b1, 20'h00100, 16'h1234);
        push(1'b1, 1'b1, 20'h00101, 16'h80A1);
        push(1'b0, 1'b0, M0_ADDR, RDATA);
        run(1, 4, 1'b0, gap);
        m1_bus.address = 20'h00101; m1_bus.writedata = 16'h80A1; m1_bus.lock = 1'b0;
        run(2, 4, 1'b1, gap);
        check("lock_m0_after_pair", gap, 1);
        idle_out();

        // Stall: five waitrequest cycles during a granted m1 write.
        m1_bus.address = 20'h00200; m1_bus.writedata = 16'h5A5A; m1_bus.write = 1'b1;
        m0_bus.read = 1'b1;
        s_bus.waitrequest = 1'b1;
        sample(); to_drive();
        for (int k = 0; k < 5; k++) begin
            sample();
            check("stall_grant", grant, 2'b10);
            check("stall_s_write", s_bus.write, 1'b1);
            check("stall_s_address", s_bus.address, 20'h00200);
            check("stall_s_wdata", s_bus.writedata, 16'h5A5A);
            check("stall_m1_wait", m1_bus.waitrequest, 1'b1);
            check("stall_m0_wait", m0_bus.waitrequest, 1'b1);
            to_drive();
        end
        s_bus.waitrequest = 1'b0;
        push(1'b1, 1'b1, 20'h00200, 16'h5A5A);
        push(1'b0, 1'b0, M0_ADDR, RDATA);
        run(2, 6, 1'b1, gap);
        check("stall_release_gap", gap, 1);
        idle_out();

        // Reset asserted while m1 is granted and stalled mid-write.
        m1_bus.address = M1_ADDR; m1_bus.writedata = M1_WDATA; m1_bus.write = 1'b1;
        s_bus.waitrequest = 1'b1;
        sample(); to_drive();
        #2;
        check("prerst_s_write", s_bus.write, 1'b1);
        check("prerst_grant", grant, 2'b10);
        reset_n = 1'b0;
        #1;
        check("midrst_s_write", s_bus.write, 1'b0);
        check("midrst_grant", grant, 2'b00);
        check("midrst_m1_wait", m1_bus.waitrequest, 1'b1);
        to_drive();
        to_drive();
        reset_n = 1'b1;
        s_bus.waitrequest = 1'b0;
        m0_bus.read = 1'b1;
        push(1'b0, 1'b0, M0_ADDR, RDATA);
        push(1'b1, 1'b1, M1_ADDR, M1_WDATA);
        run(2, 8, 1'b1, gap);
        check("postrst_gap", gap, 1);
        idle_out();

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
